// File: rtl/adder_3_bit_pkg.sv
// rtl/adder_3_bit_pkg.sv - shared width constant and operand type for the registered 3-bit adder
package adder_3_bit_pkg;

  // Operand and sum width; the adder is only characterised at this width.
  localparam int ADDER_WIDTH = 3;

  // Unsigned operand / sum word.
  typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : adder_3_bit_pkg

// File: rtl/adder_3_bit_full_adder.sv
// rtl/adder_3_bit_full_adder.sv - single-bit full adder cell used as one stage of the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term shared by sum and carry so the carry form reads as generate | propagate&ci.
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/adder_3_bit.sv
// rtl/adder_3_bit.sv - registered ripple-carry adder {Cout,S}=A+B+Cin; V output present with ADDER_3_BIT_OVERFLOW_EN
module adder_3_bit
  import adder_3_bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef ADDER_3_BIT_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  // Carry chain: c[0] is the carry-in, c[WIDTH] is the carry-out of the top stage.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_comb;

  assign c[0] = Cin;

  // One full adder per bit, each feeding its carry to the next stage up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum_comb[i]),
      .co (c[i+1])
    );
  end

  // Output register: results appear one edge after the operands; reset clears asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum_comb;
      Cout <= c[WIDTH];
    end
  end

`ifdef ADDER_3_BIT_OVERFLOW_EN
  // Signed overflow register: carry into and out of the sign bit disagree exactly on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      V <= 1'b0;
    end else begin
      V <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule : adder_3_bit

// File: tb/tb_adder_3_bit.sv
// tb/tb_adder_3_bit.sv - scoreboard bench for adder_3_bit: directed vectors, full sweep, async reset
module tb_adder_3_bit;
  import adder_3_bit_pkg::*;

  typedef struct {
    logic [2:0] s;
    logic       c;
    logic       v;
    string      name;
  } exp_t;

  logic     clk;
  logic     rst;
  operand_t A;
  operand_t B;
  logic     Cin;
  operand_t S;
  logic     Cout;
`ifdef ADDER_3_BIT_OVERFLOW_EN
  logic     V;
`endif

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  adder_3_bit #(.WIDTH(ADDER_WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
`ifdef ADDER_3_BIT_OVERFLOW_EN
    ,
    .V    (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Compare every output word (S, Cout and V when present) against an expectation.
  task automatic check_outputs(input string name, input logic [2:0] es, input logic ec, input logic ev);
    check({name, ".S"}, {1'b0, S}, {1'b0, es});
    check({name, ".Cout"}, {3'b0, Cout}, {3'b0, ec});
`ifdef ADDER_3_BIT_OVERFLOW_EN
    check({name, ".V"}, {3'b0, V}, {3'b0, ev});
`else
    if (ev === 1'bx) $display("unexpected x in expectation for %s", name);
`endif
  endtask

  // Drive one operation and queue its hand-computed result for the monitor.
  task automatic apply(input string name, input logic [2:0] a, input logic [2:0] b, input logic ci,
                       input logic [2:0] es, input logic ec, input logic ev);
    exp_t e;
    A   = a;
    B   = b;
    Cin = ci;
    e.s = es;
    e.c = ec;
    e.v = ev;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Independent reference: integer sum for S/Cout, signed range test for V.
  task automatic model(input int a, input int b, input int ci,
                       output logic [2:0] es, output logic ec, output logic ev);
    int sum;
    int sa;
    int sb;
    int ssum;
    sum  = a + b + ci;
    es   = 3'(sum % 8);
    ec   = (sum >= 8);
    sa   = (a >= 4) ? a - 8 : a;
    sb   = (b >= 4) ? b - 8 : b;
    ssum = sa + sb + ci;
    ev   = (ssum > 3) || (ssum < -4);
  endtask

  // Monitor: one registered result per edge, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_outputs(e.name, e.s, e.c, e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] es;
    logic       ec;
    logic       ev;
    n_checks = 0;
    n_fail   = 0;

    // Reset asserted from time zero with nonzero operands: outputs zero before any edge.
    rst = 1'b1;
    A   = 3'd3;
    B   = 3'd4;
    Cin = 1'b1;
    #2;
    check_outputs("reset_async", 3'b000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_outputs("reset_held", 3'b000, 1'b0, 1'b0);

    // Release at a falling edge; the first rising edge loads the first vector.
    @(negedge clk);
    rst = 1'b0;
    apply("sum_1_1_0", 3'b001, 3'b001, 1'b0, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    apply("sum_2_3_0", 3'b010, 3'b011, 1'b0, 3'b101, 1'b0, 1'b1);
    @(negedge clk);
    apply("carry_6_2_1", 3'b110, 3'b010, 1'b1, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    apply("carry_1_6_1", 3'b001, 3'b110, 1'b1, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    apply("nocarry_1_6_0", 3'b001, 3'b110, 1'b0, 3'b111, 1'b0, 1'b0);
    @(negedge clk);
    apply("max_7_7_1", 3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 1'b0);
    @(negedge clk);
    apply("ovf_3_3_1", 3'b011, 3'b011, 1'b1, 3'b111, 1'b0, 1'b1);
    @(negedge clk);
    apply("ovf_4_4_0", 3'b100, 3'b100, 1'b0, 3'b000, 1'b1, 1'b1);

    // Back-to-back sweep of all 128 operand combinations, new inputs every cycle.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      model(i / 16, (i / 2) % 8, i % 2, es, ec, ev);
      apply($sformatf("sweep_%0d", i), 3'((i / 16) % 8), 3'((i / 2) % 8), 1'(i % 2), es, ec, ev);
      if (i == 64) begin
        // Mid-stream reset before the edge: pending result is discarded, outputs clear at once.
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_outputs("midreset_async", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check_outputs("midreset_held", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_reset_64", 3'((i / 16) % 8), 3'((i / 2) % 8), 1'(i % 2), es, ec, ev);
      end
    end

    // Drain: the last queued result is checked on the next edge, leaving nothing pending.
    @(posedge clk);
    #3;
    check("queue_drained", 4'(exp_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder_3_bit
